mem_rmw_arbiter: RTL and testbench

- Owns a small register-file memory, 4 x 8 bits by default.
- Shares that memory between NUM_REQ requesters using round-robin arbitration.
- Executes one atomic read-modify-write per grant: READ, WRITE, INC (wrapping increment) or CLR.
- Memory array is a plain unpacked array named mem so hierarchical/memory-observation tooling can index it.

---
 rtl/mem_rmw_arbiter_pkg.sv | 21 ++
 rtl/mem_rmw_arbiter_rr_arbiter.sv | 32 +++
 rtl/mem_rmw_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_rmw_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rmw_arbiter_pkg.sv
// Shared types and default widths for the read-modify-write arbiter.
package mem_rmw_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INC   = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mem_rmw_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap.
module rr_arbiter
    import mem_rmw_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_rmw_arbiter.sv
// Round-robin shared register file executing one atomic READ/WRITE/INC/CLR per grant.
// Optional per-entry even parity with sticky err_o: define MEM_RMW_ARB_PARITY_EN.
module mem_rmw_arbiter
    import mem_rmw_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state, state_nx;
    logic [IDX_W-1:0]    rr_ptr, gnt_idx, arb_idx;
    logic [NUM_REQ-1:0]  arb_grant;
    logic                arb_any;
    logic                accept;
    op_e                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   old_word, new_word;

    function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] v);
        return v + DATA_W'(1);
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
        end else begin
            state <= state_nx;
            if (accept) gnt_idx <= arb_idx;
            if (state == ST_EXEC) rr_ptr <= IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = arb_grant;
                accept    = arb_any;
                if (arb_any) state_nx = ST_EXEC;
            end
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: begin
                rsp_valid[gnt_idx] = 1'b1;
                state_nx           = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy_o = (state != ST_IDLE);

    // accept edge: payload of the winner is held for the EXEC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op_e'(req_op[int'(arb_idx)*2 +: 2]);
            addr_q  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
        end
    end

    assign old_word = mem[addr_q];

    always_comb begin
        new_word = old_word;
        case (op_q)
            OP_WRITE: new_word = wdata_q;
            OP_INC:   new_word = inc_wrap(old_word);
            OP_CLR:   new_word = '0;
            default:  new_word = old_word;
        endcase
    end

    // EXEC stage: return the pre-op value and commit the new one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rsp_rdata <= '0;
        end else if (state == ST_EXEC) begin
            rsp_rdata <= old_word;
            if (op_q != OP_READ) mem[addr_q] <= new_word;
        end
    end

`ifdef MEM_RMW_ARB_PARITY_EN
    logic par [DEPTH];
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
            err_q <= 1'b0;
        end else if (state == ST_EXEC) begin
            if ((^old_word) != par[addr_q]) err_q <= 1'b1;
            if (op_q != OP_READ) par[addr_q] <= ^new_word;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rmw_arbiter.sv
// Randomized bench for mem_rmw_arbiter against a transaction-level memory/arbitration model.
module tb_mem_rmw_arbiter;

    localparam int NR    = 2;
    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [2*NR-1:0] req_op = '0;
    logic [AW*NR-1:0] req_addr = '0;
    logic [DW*NR-1:0] req_wdata = '0;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy_o;
    logic            err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: phase 0 idle, 1 op in flight, 2 response due
    int            ph = 0;
    int            m_ptr = 0;
    int            m_g = 0;
    int            m_op = 0;
    int            m_addr = 0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_old = '0;
    logic [DW-1:0] mmem [DEPTH];
    int            n_gnt = 0;
    int            last_gnt = 0;
    bit            fair = 1'b0;
    bit            rsp_seen = 1'b0;
    logic [DW-1:0] last_rdata = '0;

    mem_rmw_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input int op, input int a, input int d);
        req_valid[r]          = 1'b1;
        req_op[2*r +: 2]      = 2'(op);
        req_addr[AW*r +: AW]  = AW'(a);
        req_wdata[DW*r +: DW] = DW'(d);
    endtask

    // one clock: check outputs mid-cycle, then advance the model across the edge
    task automatic step();
        logic [NR-1:0] er, ev;
        int win;
        bit took;
        er = '0; ev = '0; win = -1; took = 1'b0;
        @(negedge clk);
        if (ph == 0)
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (win < 0 && req_valid[i]) win = i;
            end
        if (win >= 0) er[win] = 1'b1;
        if (ph == 2) ev[m_g] = 1'b1;
        check_eq("req_ready", req_ready, er);
        check_eq("busy_o", busy_o, ph != 0);
        check_eq("rsp_valid", rsp_valid, ev);
        check_eq("err_o", err_o, 0);
        if (ph == 2) begin
            check_eq("rsp_rdata", rsp_rdata, m_old);
            check_eq("mem_after_op", dut.mem[m_addr], mmem[m_addr]);
            last_rdata = rsp_rdata;
            rsp_seen   = 1'b1;
        end
        @(posedge clk);
        case (ph)
            0: if (win >= 0) begin
                m_g    = win;
                m_op   = int'(req_op[2*win +: 2]);
                m_addr = int'(req_addr[AW*win +: AW]);
                m_wd   = req_wdata[DW*win +: DW];
                if (fair && n_gnt > 0) check_eq("rr_order", win, (last_gnt + 1) % NR);
                last_gnt = win;
                n_gnt++;
                took = 1'b1;
                ph   = 1;
            end
            1: begin
                m_old = mmem[m_addr];
                case (m_op)
                    1: mmem[m_addr] = m_wd;
                    2: mmem[m_addr] = m_old + 8'd1;
                    3: mmem[m_addr] = '0;
                    default: ;
                endcase
                m_ptr = (m_g + 1) % NR;
                ph    = 2;
            end
            default: ph = 0;
        endcase
        #1;
        if (took) req_valid[m_g] = 1'b0;
    endtask

    task automatic run_op(input int r, input int op, input int a, input int d);
        set_req(r, op, a, d);
        rsp_seen = 1'b0;
        for (int c = 0; c < 20 && !rsp_seen; c++) step();
        check_eq("op_done", rsp_seen, 1);
        while (ph != 0) step();
    endtask

    task automatic drain();
        req_valid = '0;
        for (int c = 0; c < 10 && ph != 0; c++) step();
        check_eq("drained", ph, 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_err", err_o, 0);
        for (int a = 0; a < DEPTH; a++) check_eq("rst_mem", dut.mem[a], 0);
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        ph = 0; m_ptr = 0;
        for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #2;
        do_reset();

        run_op(0, 0, 2, 0);
        check_eq("read_after_reset", last_rdata, 8'h00);

        run_op(0, 1, 1, 8'hA5);
        run_op(0, 0, 1, 0);
        check_eq("read_back_a5", last_rdata, 8'hA5);

        run_op(1, 1, 3, 8'hFF);
        run_op(1, 2, 3, 0);
        check_eq("inc_from_ff", last_rdata, 8'hFF);
        run_op(0, 2, 3, 0);
        check_eq("inc_wrapped", last_rdata, 8'h00);
        check_eq("mem3_final", dut.mem[3], 8'h01);

        run_op(0, 3, 0, 0);
        fair  = 1'b1;
        n_gnt = 0;
        for (int c = 0; c < 60 && n_gnt < 8; c++) begin
            if (!req_valid[0]) set_req(0, 2, 0, 0);
            if (!req_valid[1]) set_req(1, 2, 0, 0);
            step();
        end
        drain();
        fair = 1'b0;
        check_eq("fair_grants", n_gnt, 8);
        check_eq("fair_mem0", dut.mem[0], 8'h08);

        run_op(1, 1, 2, 8'h77);
        set_req(0, 1, 2, 8'h3C);
        step();
        check_eq("in_exec", busy_o, 1);
        do_reset();
        check_eq("mem2_cleared", dut.mem[2], 8'h00);

        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] && $urandom_range(2) == 0)
                    set_req(r, int'($urandom_range(3)), int'($urandom_range(DEPTH-1)),
                            int'($urandom_range(255)));
                else if (req_valid[r] && $urandom_range(15) == 0)
                    req_valid[r] = 1'b0;
            end
            step();
        end
        drain();
        for (int a = 0; a < DEPTH; a++) check_eq("final_mem", dut.mem[a], mmem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
